// File: rtl/srl_pair_loader_checker_if.sv
// Control handshake and SRL pair bus for the SRL loader/checker.
interface srl_pair_loader_checker_if;
  localparam int unsigned PW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  logic          start;
  logic [PW-1:0] pattern;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_count;
  logic [AW-1:0] err_addr;
  logic          srl_ce;
  logic          srl_d;
  logic [AW-1:0] srl_a;
  logic [1:0]    srl_q;

  // Requester side: issues start/pattern and returns the SRL outputs.
  modport master (
    output start, pattern, srl_q,
    input  busy, done, pass, err_count, err_addr, srl_ce, srl_d, srl_a
  );

  // Engine side.
  modport slave (
    input  start, pattern, srl_q,
    output busy, done, pass, err_count, err_addr, srl_ce, srl_d, srl_a
  );
endinterface

// File: rtl/srl_pair_loader_checker.sv
// Loads a 32-bit pattern serially into two SRLC32E shift registers,
// sweeps the read address 0..31 and checks both Q bits against it.
module srl_pair_loader_checker #(
  parameter int unsigned READ_LATENCY = 1  // 1..4 cycles from srl_a to sampling srl_q
) (
  input  logic                      clk,
  input  logic                      rst_n,
  srl_pair_loader_checker_if.slave  bus
);

  localparam int unsigned PW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, LOAD, READ, REPORT} state_t;

  state_t        state_q, state_nx;
  logic [PW-1:0] p_q, p_nx;
  logic [AW-1:0] cnt_q, cnt_nx;
  logic [AW-1:0] a_q, a_nx;
  logic          issue_q, issue_nx;
  logic          ce_q, ce_nx;
  logic          d_q, d_nx;
  logic          busy_q, busy_nx;
  logic          done_q, done_nx;
  logic          pass_q, pass_nx;
  logic [CW-1:0] errc_q, errc_nx;
  logic [AW-1:0] erra_q, erra_nx;
  logic          mism;

  // Compare-side view of the issued address, delayed to line up with srl_q.
  logic          cmp_v;
  logic [AW-1:0] cmp_a;

  if (READ_LATENCY <= 1) begin : g_lat1
    assign cmp_v = issue_q;
    assign cmp_a = a_q;
  end else begin : g_latn
    localparam int unsigned D = READ_LATENCY - 1;
    logic [D-1:0]  v_dly;
    logic [AW-1:0] a_dly [D];

    // Address/valid delay line matching the SRL read latency.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_dly <= '0;
        for (int i = 0; i < int'(D); i++) a_dly[i] <= '0;
      end else begin
        v_dly[0] <= issue_q;
        a_dly[0] <= a_q;
        for (int i = 1; i < int'(D); i++) begin
          v_dly[i] <= v_dly[i-1];
          a_dly[i] <= a_dly[i-1];
        end
      end
    end

    assign cmp_v = v_dly[D-1];
    assign cmp_a = a_dly[D-1];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state_q;
    p_nx     = p_q;
    cnt_nx   = cnt_q;
    a_nx     = a_q;
    issue_nx = issue_q;
    ce_nx    = 1'b0;
    d_nx     = 1'b0;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    pass_nx  = pass_q;
    errc_nx  = errc_q;
    erra_nx  = erra_q;
    mism     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          p_nx     = bus.pattern;
          cnt_nx   = '0;
          pass_nx  = 1'b0;
          errc_nx  = '0;
          erra_nx  = '0;
          busy_nx  = 1'b1;
          ce_nx    = 1'b1;
          d_nx     = bus.pattern[PW-1];
          state_nx = LOAD;
        end
      end
      LOAD: begin
        // MSB first, so after 32 shifts address k holds p[k].
        if (cnt_q == AW'(PW - 1)) begin
          cnt_nx   = '0;
          a_nx     = '0;
          issue_nx = 1'b1;
          state_nx = READ;
        end else begin
          cnt_nx = cnt_q + AW'(1);
          ce_nx  = 1'b1;
          d_nx   = p_q[~cnt_nx];
        end
      end
      READ: begin
        if (issue_q) begin
          if (a_q == AW'(PW - 1)) issue_nx = 1'b0;
          else                    a_nx     = a_q + AW'(1);
        end
        if (cmp_v) begin
          mism = (bus.srl_q[0] != p_q[cmp_a]) || (bus.srl_q[1] != p_q[cmp_a]);
          if (mism) begin
            if (errc_q == '0)      erra_nx = cmp_a;
            if (errc_q != CW'(PW)) errc_nx = errc_q + CW'(1);
          end
          if (cmp_a == AW'(PW - 1)) begin
            state_nx = REPORT;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            pass_nx  = (errc_nx == '0);
            a_nx     = '0;
            issue_nx = 1'b0;
          end
        end
      end
      REPORT: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops srl_ce immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      issue_q <= 1'b0;
      ce_q    <= 1'b0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      errc_q  <= '0;
      erra_q  <= '0;
    end else begin
      state_q <= state_nx;
      p_q     <= p_nx;
      cnt_q   <= cnt_nx;
      a_q     <= a_nx;
      issue_q <= issue_nx;
      ce_q    <= ce_nx;
      d_q     <= d_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
      pass_q  <= pass_nx;
      errc_q  <= errc_nx;
      erra_q  <= erra_nx;
    end
  end

  assign bus.srl_ce    = ce_q;
  assign bus.srl_d     = d_q;
  assign bus.srl_a     = a_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = errc_q;
  assign bus.err_addr  = erra_q;

endmodule

// File: tb/tb_srl_pair_loader_checker.sv
// Directed bench for the SRL pair loader/checker at read latency 1 and 2.
module tb_srl_pair_loader_checker;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Stimulus and selection between the two instances.
  logic        sel;
  logic        start_r;
  logic [31:0] pat_r;
  int          mode;

  srl_pair_loader_checker_if ifa ();
  srl_pair_loader_checker_if ifb ();

  srl_pair_loader_checker #(.READ_LATENCY(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  srl_pair_loader_checker #(.READ_LATENCY(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  assign ifa.start   = start_r & ~sel;
  assign ifb.start   = start_r & sel;
  assign ifa.pattern = pat_r;
  assign ifb.pattern = pat_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRL pair model for instance A: combinational read, optional faults.
  logic [31:0] sa0, sa1;
  logic        qa0, qa1;
  always @(posedge clk) begin
    if (ifa.srl_ce) begin
      sa0 <= {sa0[30:0], ifa.srl_d};
      sa1 <= {sa1[30:0], ifa.srl_d};
    end
  end
  assign qa0 = sa0[ifa.srl_a] ^ ((mode == 2) && (ifa.srl_a == 5'd7 || ifa.srl_a == 5'd20));
  assign qa1 = (mode == 1) ? 1'b0 : sa1[ifa.srl_a];
  assign ifa.srl_q = {qa1, qa0};

  // SRL pair model for instance B: registered read.
  logic [31:0] sb0, sb1;
  logic [1:0]  qb;
  always @(posedge clk) begin
    if (ifb.srl_ce) begin
      sb0 <= {sb0[30:0], ifb.srl_d};
      sb1 <= {sb1[30:0], ifb.srl_d};
    end
    qb <= {sb1[ifb.srl_a], sb0[ifb.srl_a]};
  end
  assign ifb.srl_q = qb;

  // Observed outputs of the selected instance.
  logic       obs_ce, obs_d, obs_busy, obs_done, obs_pass;
  logic [5:0] obs_cnt;
  logic [4:0] obs_addr, obs_a;
  assign obs_ce   = sel ? ifb.srl_ce    : ifa.srl_ce;
  assign obs_d    = sel ? ifb.srl_d     : ifa.srl_d;
  assign obs_a    = sel ? ifb.srl_a     : ifa.srl_a;
  assign obs_busy = sel ? ifb.busy      : ifa.busy;
  assign obs_done = sel ? ifb.done      : ifa.done;
  assign obs_pass = sel ? ifb.pass      : ifa.pass;
  assign obs_cnt  = sel ? ifb.err_count : ifa.err_count;
  assign obs_addr = sel ? ifb.err_addr  : ifa.err_addr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // One full run; called and returns at a negedge with the DUT in IDLE.
  task automatic run_check(input logic s, input logic [31:0] pat, input int exp_done,
                           input logic exp_pass, input int exp_cnt, input int exp_addr,
                           input logic restarts);
    int          done_seen;
    logic [31:0] pv;
    pv        = pat;
    sel       = s;
    pat_r     = pat;
    start_r   = 1'b1;
    done_seen = 0;
    @(posedge clk);
    for (int n = 1; n <= exp_done + 1; n++) begin
      @(negedge clk);
      start_r = restarts && (n == 5 || n == 40);
      if (n == 1) begin
        pat_r = ~pat;
        check_val("busy_after_start", obs_busy, 1);
        check_val("pass_cleared", obs_pass, 0);
        check_val("cnt_cleared", obs_cnt, 0);
      end
      check_val("srl_ce", obs_ce, n <= 32);
      if (n <= 32) begin
        check_val("srl_d", obs_d, pv[32-n]);
        check_val("srl_a_load", obs_a, 0);
      end
      if (obs_done) begin
        done_seen++;
        check_val("done_cycle", n, exp_done);
        check_val("pass", obs_pass, exp_pass);
        check_val("err_count", obs_cnt, exp_cnt);
        check_val("err_addr", obs_addr, exp_addr);
        check_val("busy_at_done", obs_busy, 0);
      end
    end
    start_r = 1'b0;
    check_val("done_count", done_seen, 1);
    check_val("pass_hold", obs_pass, exp_pass);
  endtask

  initial begin
    int done_flag;
    checks  = 0;
    errors  = 0;
    sel     = 1'b0;
    start_r = 1'b0;
    pat_r   = '0;
    mode    = 0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);

    check_val("rst_busy", ifa.busy, 0);
    check_val("rst_done", ifa.done, 0);
    check_val("rst_pass", ifa.pass, 0);
    check_val("rst_cnt", ifa.err_count, 0);
    check_val("rst_addr", ifa.err_addr, 0);
    check_val("rst_ce", ifa.srl_ce, 0);
    check_val("rst_d", ifa.srl_d, 0);
    check_val("rst_a", ifa.srl_a, 0);
    check_val("rst_b_ce", ifb.srl_ce, 0);

    rst_n = 1'b1;
    @(negedge clk);

    // Ideal model, latency 1.
    mode = 0;
    run_check(1'b0, 32'hA5A50F0F, 65, 1'b1, 0, 0, 1'b0);
    // Back-to-back start: Q[1] stuck at 0.
    mode = 1;
    run_check(1'b0, 32'hFFFFFFFF, 65, 1'b0, 32, 0, 1'b0);
    // Q[0] flipped at addresses 7 and 20, with ignored restarts.
    mode = 2;
    run_check(1'b0, 32'h12345678, 65, 1'b0, 2, 7, 1'b1);

    // Reset in cycle 10 of LOAD.
    mode    = 0;
    pat_r   = 32'hFFFF0000;
    start_r = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start_r = 1'b0;
    end
    check_val("ce_before_rst", ifa.srl_ce, 1);
    rst_n = 1'b0;
    #1;
    check_val("ce_on_rst", ifa.srl_ce, 0);
    check_val("busy_on_rst", ifa.busy, 0);
    done_flag = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (ifa.done) done_flag++;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 70; n++) begin
      @(negedge clk);
      if (ifa.done) done_flag++;
    end
    check_val("no_done_after_rst", done_flag, 0);
    run_check(1'b0, 32'h12345678, 65, 1'b1, 0, 0, 1'b0);

    // Registered-read SRL at latency 2.
    run_check(1'b1, 32'h80000001, 66, 1'b1, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srl_pair_loader_checker.md
Name: srl_pair_loader_checker

Overview:
- Initiator-side driver for a pair of SRLC32E shift registers that share CLK, CE, D and address A and return Q[1:0].
- On START it serially loads a 32-bit pattern into both SRLs, then sweeps the read address 0..31.
- It checks both Q bits against the pattern and reports pass/fail, the error count and the first failing address.
- Used as the on-fabric stimulus/readback engine for SRL minitests and hardware sanity checks.

Parameters:
- READ_LATENCY, 1, cycles from driving SRL_A to sampling SRL_Q (1 = combinational SRL read followed by one capture register; valid range 1..4).

Ports:
- CLK  input  1  sole clock; all SRL_* outputs are launched from it.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle request; sampled only in IDLE.
- PATTERN  input  32  word to load; latched on the accepted START.
- BUSY  output  1  high from the cycle after START is accepted until DONE is asserted.
- DONE  output  1  one-cycle pulse when the check completes.
- PASS  output  1  1 if ERR_COUNT==0; valid from DONE until the next accepted START.
- ERR_COUNT  output  6  number of addresses (0..32) where either Q bit mismatched.
- ERR_ADDR  output  5  lowest failing address; 0 if none.
- SRL_CE  output  1  shift enable to both SRLs.
- SRL_D  output  1  serial data to both SRLs.
- SRL_A  output  5  read address to both SRLs.
- SRL_Q  input  2  SRL outputs; [0]=first SRL, [1]=second SRL.

Behaviour:
- Reset (async, RST_N=0): state IDLE.
  - BUSY=0, DONE=0, PASS=0, ERR_COUNT=0, ERR_ADDR=0.
  - SRL_CE=0, SRL_D=0, SRL_A=0; all internal counters 0.
  - SRL_CE must drop immediately, not at the next edge; reset mid-LOAD or mid-READ aborts with no DONE.
- States: IDLE -> LOAD -> READ -> REPORT -> IDLE.
- IDLE:
  - START=1 at an edge latches PATTERN into P.
  - Clears PASS, ERR_COUNT and ERR_ADDR; enters LOAD with bit counter 0.
- LOAD: exactly 32 cycles.
  - SRL_CE=1, SRL_D=P[31-cnt], i.e. MSB first.
  - After the 32nd shift, address k holds P[k] in both SRLs.
  - SRL_A is held at 0. Enters READ after cnt==31.
- READ:
  - SRL_CE=0. SRL_A=0,1,...,31 on consecutive cycles; issue counter stops after 31.
  - Compare pipeline: address issued at cycle t is compared at cycle t+READ_LATENCY using a delayed copy of the address.
  - Comparison is SRL_Q[0]!=P[a] or SRL_Q[1]!=P[a]; a mismatch on both bits counts once.
  - ERR_COUNT increments on each failing compare and saturates at 32 (cannot exceed by construction).
  - ERR_ADDR is captured on the first failure only.
  - READ lasts 32+READ_LATENCY-1 cycles, ending when compare address 31 completes.
- REPORT: one cycle.
  - DONE=1, PASS=(ERR_COUNT==0), BUSY=0.
  - Next state is IDLE.
- Timing: START sampled at edge 0 -> SRL_CE high cycles 1..32 -> DONE at cycle 64+READ_LATENCY.
- START while BUSY or in REPORT is ignored, with no queuing. START in the cycle right after DONE is accepted.
- PATTERN changes after acceptance have no effect.
- Outputs are registered; no combinational path from SRL_Q or START to any output.

Test Plan:
- Ideal SRL model, READ_LATENCY=1, PATTERN=0xA5A50F0F -> SRL_CE high exactly 32 cycles with D sequence P[31]..P[0]; DONE at cycle 65; PASS=1, ERR_COUNT=0, ERR_ADDR=0.
- Model with Q[1] stuck at 0, PATTERN=0xFFFFFFFF -> PASS=0, ERR_COUNT=32, ERR_ADDR=0.
- Model with Q[0] inverted only at address 7 and address 20, PATTERN=0x12345678 -> ERR_COUNT=2, ERR_ADDR=7.
- START re-asserted at cycles 5 and 40 of a run -> ignored, single DONE at 65. START on the cycle after DONE -> new run begins, and PASS is cleared on acceptance.
- RST_N low at cycle 10 of LOAD -> SRL_CE=0 within the same cycle, no DONE. A fresh START after release -> correct full run.
- READ_LATENCY=2 with a registered-read SRL model, PATTERN=0x80000001 -> PASS=1, DONE at cycle 66.
